fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 8x8 buffer.
//  Adds configurable width/depth, programmable almost-full/almost-empty thresholds,
//  overflow/underflow error pulses, synchronous flush and an optional first-word-fall-through (FWFT) read mode.
//  Sits between producer/consumer blocks sharing clk, e.g. UART/SPI data staging.
// PARAMETERS
//  DATA_W   8  data width in bits (>=1)
//  DEPTH    8  number of entries (>=2; non-power-of-2 legal)
//  AF_LEVEL 6  almost_full asserted when fifo_cnt >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL 1  almost_empty asserted when fifo_cnt <= AE_LEVEL (0..DEPTH-1)
//  FWFT     0  0 = standard registered read; 1 = first-word-fall-through
//  CNT_W    $clog2(DEPTH+1)  count width (derived localparam, not overridable)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous reset, active-high
//  clr          in   1       synchronous flush, active-high
//  wr           in   1       write request
//  data_in      in   DATA_W  write data, sampled when write accepted
//  rd           in   1       read request
//  data_out     out  DATA_W  read data
//  fifo_cnt     out  CNT_W   current occupancy, 0..DEPTH
//  full         out  1       fifo_cnt == DEPTH
//  empty        out  1       fifo_cnt == 0
//  almost_full  out  1       fifo_cnt >= AF_LEVEL
//  almost_empty out  1       fifo_cnt <= AE_LEVEL
//  overflow     out  1       1-cycle pulse: write rejected
//  underflow    out  1       1-cycle pulse: read rejected
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): wr/rd ptrs=0, fifo_cnt=0, data_out=0,
//    empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0. Memory contents not reset.
//  - rd_ok = rd & !empty; wr_ok = wr & (!full | rd_ok). Full + rd + wr: both accepted, count unchanged.
//  - Empty + rd + wr: write accepted, read rejected (underflow=1), count 0->1.
//  - overflow = wr & !wr_ok; underflow = rd & !rd_ok; registered, high exactly one cycle after the offending edge.
//  - fifo_cnt: +1 on wr_ok only, -1 on rd_ok only, unchanged on both/neither; never exceeds DEPTH or goes below 0.
//  - All flags decode from the registered count; they change on the same edge as fifo_cnt.
//  - Pointers increment on accept; wrap DEPTH-1 -> 0 explicitly (no power-of-2 assumption).
//  - FWFT=0: data_out registered; on rd_ok, data_out <= mem[rd_ptr], visible 1 cycle after the rd edge;
//    holds last value otherwise (including when empty and on clr).
//  - FWFT=1: data_out = mem[rd_ptr] combinationally whenever !empty (0 latency); rd_ok pops;
//    data_out don't-care while empty. A write to an empty FIFO is visible on data_out the cycle after the write edge.
//  - clr: highest priority below rst; ptrs=0, fifo_cnt=0, flags as reset; wr/rd that cycle ignored,
//    no overflow/underflow pulse. data_out behaves per FWFT rule above.
//  - Reset mid-operation: all state returns to reset values immediately, regardless of clk.
// TESTING (DATA_W=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1; run FWFT=0 and FWFT=1)
//  1. Reset, write 0,5,..,35 (8 writes) -> fifo_cnt 1..8, almost_full at cnt 6, full at 8, almost_empty clears at cnt 2.
//  2. Read 8 -> data 0,5,..,35 in order (FWFT=0: 1-cycle lag; FWFT=1: head visible before rd), empty at end.
//  3. Full, wr=1 data 99 -> overflow 1 cycle, cnt stays 8; empty, rd=1 -> underflow 1 cycle, cnt 0.
//  4. Full, wr=rd=1 for 20 cycles, incrementing data -> cnt stays 8, no error pulses, order preserved across ptr wrap.
//  5. Empty, wr=rd=1 data 0xA5 -> underflow pulse, cnt 1, 0xA5 read next.
//  6. cnt=4, assert clr with wr=1 -> cnt 0, empty=1, no pulses; assert rst mid-burst -> all outputs to reset values.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty levels,
// overflow/underflow pulses, synchronous flush and optional first-word-fall-through read.
module fifo_sync_param #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 1,
   parameter int FWFT     = 0,
   localparam int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd,
   output logic [DATA_W-1:0] data_out,
   output logic [CNT_W-1:0]  fifo_cnt,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              rd_ok, wr_ok;

   // A flush swallows both requests, so neither can be accepted nor flagged as an error.
   always_comb begin
      rd_ok    = rd & ~empty & ~clr;
      wr_ok    = wr & (~full | (rd & ~empty)) & ~clr;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      ovf_d    = wr & ~wr_ok & ~clr;
      udf_d    = rd & ~rd_ok & ~clr;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (wr_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage is deliberately left out of reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= data_in;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = empty ? '0 : mem_q[rd_ptr_q];
      end else begin : g_std
         logic [DATA_W-1:0] dout_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)        dout_q <= '0;
            else if (rd_ok) dout_q <= mem_q[rd_ptr_q];
         end
         assign data_out = dout_q;
      end
   endgenerate

   assign fifo_cnt     = cnt_q;
   assign full         = (cnt_q == CNT_FULL);
   assign empty        = (cnt_q == '0);
   assign almost_full  = (cnt_q >= CNT_AF);
   assign almost_empty = (cnt_q <= CNT_AE);
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench driving a standard-read and a FWFT instance of fifo_sync_param in lockstep.
module tb_fifo_sync_param;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst, clr, wr, rd;
   logic [DW-1:0] data_in;

   logic [DW-1:0] dout_s  [2];
   logic [CW-1:0] cnt_s   [2];
   logic          full_s  [2];
   logic          empty_s [2];
   logic          af_s    [2];
   logic          ae_s    [2];
   logic          ovf_s   [2];
   logic          udf_s   [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         fifo_sync_param #(
            .DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(gi)
         ) u_dut (
            .clk(clk), .rst(rst), .clr(clr), .wr(wr), .data_in(data_in), .rd(rd),
            .data_out(dout_s[gi]), .fifo_cnt(cnt_s[gi]), .full(full_s[gi]),
            .empty(empty_s[gi]), .almost_full(af_s[gi]), .almost_empty(ae_s[gi]),
            .overflow(ovf_s[gi]), .underflow(udf_s[gi])
         );
      end
   endgenerate

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int mdl[$];
   int exp_q0[$];
   int exp_q1[$];
   bit pend0 = 1'b0;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic void pop_cmp(input int i);
      int v;
      if (i == 0) begin
         if (exp_q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rdata[0]: got %0h expected nothing (scoreboard empty)", dout_s[0]);
            return;
         end
         v = exp_q0.pop_front();
      end else begin
         if (exp_q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rdata[1]: got %0h expected nothing (scoreboard empty)", dout_s[1]);
            return;
         end
         v = exp_q1.pop_front();
      end
      check($sformatf("rdata[%0d]", i), 32'(dout_s[i]), 32'(v));
      $display("read  fwft=%0d data=%0d expected=%0d", i, dout_s[i], v);
   endfunction

   // Standard mode shows popped data one cycle after the read edge; FWFT shows the head before it.
   always @(negedge clk) begin
      if (!rst) begin
         if (pend0) pop_cmp(0);
         pend0 = rd && !empty_s[0] && !clr;
         if (rd && !empty_s[1] && !clr) pop_cmp(1);
      end
   end

   task automatic check_state(input bit eo, input bit eu, input string tag);
      int sz;
      sz = mdl.size();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s cnt[%0d]", tag, i), 32'(cnt_s[i]), 32'(sz));
         check($sformatf("%s flags[%0d] {full,empty,af,ae,ovf,udf}", tag, i),
               {26'd0, full_s[i], empty_s[i], af_s[i], ae_s[i], ovf_s[i], udf_s[i]},
               {26'd0, sz == DEPTH, sz == 0, sz >= AF, sz <= AE, eo, eu});
      end
   endtask

   task automatic cycle(input bit w, input bit r, input int d, input bit c, input string tag);
      bit rok, wok, eo, eu;
      int v;
      wr = w; rd = r; data_in = d[DW-1:0]; clr = c;
      eo = 1'b0; eu = 1'b0;
      if (c) begin
         mdl.delete();
      end else begin
         rok = r && (mdl.size() != 0);
         wok = w && ((mdl.size() != DEPTH) || rok);
         if (rok) begin
            v = mdl.pop_front();
            exp_q0.push_back(v);
            exp_q1.push_back(v);
         end
         if (wok) mdl.push_back(d);
         eo = w && !wok;
         eu = r && !rok;
      end
      @(posedge clk); #1;
      $display("cycle %-6s wr=%0d rd=%0d clr=%0d din=%0d cnt=%0d ovf=%0d udf=%0d",
               tag, w, r, c, d, cnt_s[0], ovf_s[0], udf_s[0]);
      check_state(eo, eu, tag);
      wr = 1'b0; rd = 1'b0; clr = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s cnt[%0d]", tag, i), 32'(cnt_s[i]), 32'd0);
         check($sformatf("%s flags[%0d] {full,empty,af,ae,ovf,udf}", tag, i),
               {26'd0, full_s[i], empty_s[i], af_s[i], ae_s[i], ovf_s[i], udf_s[i]},
               32'b010100);
      end
      check({tag, " dout[0]"}, 32'(dout_s[0]), 32'd0);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;

      // fill 0,5,..,35 then push into a full FIFO
      for (int k = 0; k < 8; k++) cycle(1, 0, k * 5, 0, "fill");
      cycle(1, 0, 99, 0, "ovf");
      cycle(0, 0, 0, 0, "idle");
      // drain in order, then read while empty
      for (int k = 0; k < 8; k++) cycle(0, 1, 0, 0, "drain");
      cycle(0, 1, 0, 0, "udf");
      cycle(0, 0, 0, 0, "idle");

      // simultaneous read/write on a full FIFO across pointer wrap
      for (int k = 0; k < 8; k++) cycle(1, 0, 200 + k, 0, "fill2");
      for (int k = 0; k < 20; k++) cycle(1, 1, 100 + k, 0, "rdwr");
      for (int k = 0; k < 8; k++) cycle(0, 1, 0, 0, "drain2");
      cycle(0, 0, 0, 0, "idle");

      // empty with wr+rd: write wins, read flagged
      cycle(1, 1, 8'hA5, 0, "emprw");
      cycle(0, 1, 0, 0, "rdA5");
      cycle(0, 0, 0, 0, "idle");

      // flush at cnt 4 with a write pending
      for (int k = 0; k < 4; k++) cycle(1, 0, 50 + k, 0, "fill3");
      cycle(1, 1, 77, 1, "clr");
      cycle(0, 0, 0, 0, "idle");
      check("scoreboard0 leftover", 32'(exp_q0.size()), 32'd0);
      check("scoreboard1 leftover", 32'(exp_q1.size()), 32'd0);

      // asynchronous reset in the middle of a write burst
      for (int k = 0; k < 3; k++) cycle(1, 0, 60 + k, 0, "fill4");
      wr = 1'b1; data_in = 8'd63;
      #3;
      rst = 1'b1;
      #1;
      check_reset("async_rst");
      $display("cycle async reset asserted mid-burst cnt=%0d", cnt_s[0]);
      mdl.delete(); exp_q0.delete(); exp_q1.delete(); pend0 = 1'b0;
      wr = 1'b0;
      @(posedge clk); #1;
      check_reset("rst_hold");
      rst = 1'b0;
      cycle(0, 0, 0, 0, "post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
